spram_bank_ctrl: RTL and testbench

Controller that sequences the four-bank SPRAM instruction/data memory (16-bit word address, 14-bit per-bank address, bank = addr[15:14]). It shares the memory between a read-only fetch port (A) and a load/store port (B) with round-robin arbitration. It expands byte enables to the SPRAM nibble mask. It power-gates idle banks through their sleep pins, inserting wake-up cycles on the next access. It sits between the processor's fetch/LSU ports and the SPRAM bank instances.

---
 rtl/spram_ctrl_pkg.sv | 30 +++
 rtl/spram_idle_timer.sv | 30 +++
 rtl/spram_bank_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spram_bank_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the SPRAM bank controller.
package spram_ctrl_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned BANK_AW   = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAKE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  // Each byte enable drives the two nibble write-mask bits covering that byte.
  function automatic logic [7:0] be_to_nibble_mask(input logic [3:0] be);
    logic [7:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[2*i]   = be[i];
      mask[2*i+1] = be[i];
    end
    return mask;
  endfunction

endpackage

// File: rtl/spram_idle_timer.sv
// Per-bank idle counter: saturates at IDLE_CYCLES, which asserts sleep.
// Used only when SPRAM_POWER_GATE_EN is defined.
module spram_idle_timer #(
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic sleep
);

  localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] count;

  // Saturating idle count; clear wins over increment, reset leaves the bank asleep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CMAX;
    end else if (clear) begin
      count <= '0;
    end else if (count != CMAX) begin
      count <= count + CW'(1);
    end
  end

  assign sleep = (count == CMAX);

endmodule

// File: rtl/spram_bank_ctrl.sv
// Four-bank SPRAM controller: round-robin sharing between fetch port A and
// load/store port B, byte-enable to nibble-mask expansion, and optional
// idle power gating of banks (enabled by defining SPRAM_POWER_GATE_EN).
module spram_bank_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req,
  input  logic [15:0]  a_addr,
  output logic         a_ack,
  output logic [31:0]  a_rdata,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [15:0]  b_addr,
  input  logic [31:0]  b_wdata,
  input  logic [3:0]   b_be,
  output logic         b_ack,
  output logic [31:0]  b_rdata,
  output logic [13:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [7:0]   mem_mask_wren,
  output logic         mem_wren,
  output logic [3:0]   mem_cs,
  output logic [3:0]   mem_sleep,
  output logic [3:0]   mem_standby,
  output logic [3:0]   mem_poweroff,
  input  logic [127:0] mem_rdata
);

  state_t state, state_nx;
  port_t  last_grant, winner, gnt_port;

  logic        cand_a, cand_b, grant;
  logic [15:0] gnt_addr;
  logic [1:0]  gnt_bank, cur_bank;
  logic [15:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [7:0]  mask_q;
  logic [31:0] bank_rdata;
  logic [NUM_BANKS-1:0] sleep_w;
  logic        wake_done;

  assign cur_bank = addr_q[15:BANK_AW];

  // Arbitration: round-robin on ties; the port acked in RESP cannot win again.
  always_comb begin
    cand_a   = a_req && !(state == ST_RESP && winner == PORT_A);
    cand_b   = b_req && !(state == ST_RESP && winner == PORT_B);
    grant    = (state == ST_IDLE || state == ST_RESP) && (cand_a || cand_b);
    gnt_port = PORT_A;
    if (cand_a && cand_b) begin
      gnt_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (cand_b) begin
      gnt_port = PORT_B;
    end
    gnt_addr = (gnt_port == PORT_A) ? a_addr : b_addr;
    gnt_bank = gnt_addr[15:BANK_AW];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: grant goes through WAKE only when the target bank is asleep.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (grant) begin
          state_nx = sleep_w[gnt_bank] ? ST_WAKE : ST_ACCESS;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAKE:   if (wake_done) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Transaction fields latched at the grant; A grants never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_B;
      winner     <= PORT_A;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      mask_q     <= '0;
    end else if (grant) begin
      last_grant <= gnt_port;
      winner     <= gnt_port;
      addr_q     <= gnt_addr;
      if (gnt_port == PORT_B) begin
        we_q    <= b_we;
        wdata_q <= b_wdata;
        mask_q  <= b_we ? be_to_nibble_mask(b_be) : '0;
      end else begin
        we_q    <= 1'b0;
        wdata_q <= '0;
        mask_q  <= '0;
      end
    end
  end

  assign mem_addr      = addr_q[BANK_AW-1:0];
  assign mem_wdata     = wdata_q;
  assign mem_mask_wren = mask_q;
  assign mem_cs        = (state == ST_ACCESS) ? (4'b0001 << cur_bank) : '0;
  assign mem_wren      = (state == ST_ACCESS) && we_q;
  assign mem_standby   = '0;
  assign mem_poweroff  = '1;

  assign bank_rdata = mem_rdata[{cur_bank, 5'b0} +: 32];
  assign a_ack      = (state == ST_RESP) && (winner == PORT_A);
  assign b_ack      = (state == ST_RESP) && (winner == PORT_B);
  assign a_rdata    = a_ack ? bank_rdata : '0;
  assign b_rdata    = (b_ack && !we_q) ? bank_rdata : '0;

`ifdef SPRAM_POWER_GATE_EN
  localparam int unsigned WCW = $clog2(WAKE_CYCLES) + 1;

  logic [WCW-1:0]       wcnt;
  logic [NUM_BANKS-1:0] timer_clear;
  logic                 busy;

  assign busy      = (state == ST_WAKE) || (state == ST_ACCESS) || (state == ST_RESP);
  assign wake_done = (state == ST_WAKE) && (wcnt == WCW'(WAKE_CYCLES - 1));

  // Wake-up delay counter, restarted whenever the FSM is outside WAKE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (state != ST_WAKE) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WCW'(1);
    end
  end

  // Clear also covers the grant cycle so a bank granted as its count saturates stays awake.
  always_comb begin
    timer_clear = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      timer_clear[k] = (busy && cur_bank == 2'(k)) || (grant && gnt_bank == 2'(k));
    end
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_timer
    spram_idle_timer #(
      .IDLE_CYCLES(IDLE_CYCLES)
    ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (timer_clear[k]),
      .sleep (sleep_w[k])
    );
  end

  assign mem_sleep = sleep_w;
`else
  logic unused_cfg;

  assign unused_cfg = ^{IDLE_CYCLES, WAKE_CYCLES};
  assign sleep_w    = '0;
  assign wake_done  = 1'b1;
  assign mem_sleep  = '0;
`endif

endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Randomized bench for spram_bank_ctrl with a transaction-level reference
// model and a behavioural model of the four SPRAM banks.
module tb_spram_bank_ctrl;

  localparam int unsigned IDLE = 8;
  localparam int unsigned WAKE = 2;
`ifdef SPRAM_POWER_GATE_EN
  localparam bit PG = 1'b1;
`else
  localparam bit PG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_req = 1'b0;
  logic [15:0]  a_addr = '0;
  logic         a_ack;
  logic [31:0]  a_rdata;
  logic         b_req = 1'b0;
  logic         b_we = 1'b0;
  logic [15:0]  b_addr = '0;
  logic [31:0]  b_wdata = '0;
  logic [3:0]   b_be = '0;
  logic         b_ack;
  logic [31:0]  b_rdata;
  logic [13:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [7:0]   mem_mask_wren;
  logic         mem_wren;
  logic [3:0]   mem_cs;
  logic [3:0]   mem_sleep;
  logic [3:0]   mem_standby;
  logic [3:0]   mem_poweroff;
  logic [127:0] mem_rdata;

  logic [31:0] rq [4];
  logic [31:0] smem [4][16384];
  logic [31:0] ref_mem [65536];

  assign mem_rdata = {rq[3], rq[2], rq[1], rq[0]};

  spram_bank_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a_req         (a_req),
    .a_addr        (a_addr),
    .a_ack         (a_ack),
    .a_rdata       (a_rdata),
    .b_req         (b_req),
    .b_we          (b_we),
    .b_addr        (b_addr),
    .b_wdata       (b_wdata),
    .b_be          (b_be),
    .b_ack         (b_ack),
    .b_rdata       (b_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_mask_wren (mem_mask_wren),
    .mem_wren      (mem_wren),
    .mem_cs        (mem_cs),
    .mem_sleep     (mem_sleep),
    .mem_standby   (mem_standby),
    .mem_poweroff  (mem_poweroff),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPRAM banks: nibble-masked write, registered read data.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_cs[k]) begin
        if (mem_wren) begin
          logic [31:0] w;
          w = smem[k][mem_addr];
          for (int n = 0; n < 8; n++) begin
            if (mem_mask_wren[n]) w[4*n +: 4] = mem_wdata[4*n +: 4];
          end
          smem[k][mem_addr] = w;
        end else begin
          rq[k] = smem[k][mem_addr];
        end
      end
    end
  end

  typedef struct {
    bit          v;
    bit          is_b;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rexp;
    int          acc_c;
    int          ack_c;
  } txn_t;

  txn_t pend [2];
  int   bstart [4];
  int   bend [4];
  int   bprev [4];
  bit   last_a;
  int   vectors = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      bstart[k] = -1000;
      bend[k]   = -1000;
      bprev[k]  = -1000;
    end
    last_a    = 1'b0;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
  endfunction

  // A bank sleeps once IDLE whole cycles have passed since its last busy cycle.
  function automatic bit asleep(input int k, input int t);
    int e;
    if (!PG) return 1'b0;
    if (t > bstart[k]) begin
      if (t <= bend[k] + 1) return 1'b0;
      e = bend[k];
    end else begin
      e = bprev[k];
    end
    return (t - e - 1) >= int'(IDLE);
  endfunction

  function automatic void mark_busy(input int k, input int s, input int e);
    if (s <= bend[k] + 1) begin
      if (e > bend[k]) bend[k] = e;
    end else begin
      bprev[k]  = bend[k];
      bstart[k] = s;
      bend[k]   = e;
    end
  endfunction

  task automatic predict(input int i, input int g);
    int k;
    k = int'(pend[i].addr[15:14]);
    pend[i].acc_c = g + 1 + (asleep(k, g) ? int'(WAKE) : 0);
    pend[i].ack_c = pend[i].acc_c + 1;
    mark_busy(k, g, pend[i].ack_c);
    pend[i].rexp = '0;
    if (pend[i].we) begin
      logic [31:0] w;
      w = ref_mem[pend[i].addr];
      for (int b = 0; b < 4; b++) begin
        if (pend[i].be[b]) w[8*b +: 8] = pend[i].wdata[8*b +: 8];
      end
      ref_mem[pend[i].addr] = w;
    end else begin
      pend[i].rexp = ref_mem[pend[i].addr];
    end
    pend[i].v = 1'b1;
  endtask

  // Compares every observable output at the current negedge.
  task automatic step_check();
    logic        ea, eb, ewr;
    logic [31:0] era, erb;
    logic [3:0]  ecs, esl;
    logic [7:0]  em;
    ea = 1'b0; eb = 1'b0; ewr = 1'b0; era = '0; erb = '0; ecs = '0;
    for (int i = 0; i < 2; i++) begin
      if (pend[i].v) begin
        if (pend[i].acc_c == cyc) begin
          ecs = 4'b0001 << pend[i].addr[15:14];
          ewr = pend[i].we;
          check("mem_addr", 32'(mem_addr), 32'(pend[i].addr[13:0]));
          if (pend[i].we) begin
            for (int n = 0; n < 8; n++) em[n] = pend[i].be[n/2];
            check("mem_wdata", mem_wdata, pend[i].wdata);
            check("mem_mask_wren", 32'(mem_mask_wren), 32'(em));
          end
        end
        if (pend[i].ack_c == cyc) begin
          if (pend[i].is_b) begin
            eb  = 1'b1;
            erb = pend[i].we ? '0 : pend[i].rexp;
          end else begin
            ea  = 1'b1;
            era = pend[i].rexp;
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) esl[k] = asleep(k, cyc);
    check("a_ack", 32'(a_ack), 32'(ea));
    check("b_ack", 32'(b_ack), 32'(eb));
    check("a_rdata", a_rdata, era);
    check("b_rdata", b_rdata, erb);
    check("mem_cs", 32'(mem_cs), 32'(ecs));
    check("mem_wren", 32'(mem_wren), 32'(ewr));
    check("mem_sleep", 32'(mem_sleep), 32'(esl));
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      step_check();
    end
  endtask

  // One request round starting at the current negedge (controller idle).
  task automatic round(input bit ra, input bit rb, input logic [15:0] aa, input logic [15:0] ba,
                       input bit bwe, input logic [31:0] bwd, input logic [3:0] bbe);
    int c, last, f, s;
    c = cyc;
    pend[0] = '{v: 1'b0, is_b: 1'b0, we: 1'b0, addr: aa, wdata: '0, be: '0, rexp: '0, acc_c: 0, ack_c: 0};
    pend[1] = '{v: 1'b0, is_b: 1'b1, we: bwe, addr: ba, wdata: bwd, be: bbe, rexp: '0, acc_c: 0, ack_c: 0};
    f = (ra && rb) ? (last_a ? 1 : 0) : (rb ? 1 : 0);
    s = 1 - f;
    predict(f, c);
    last = pend[f].ack_c;
    last_a = (f == 0);
    if (ra && rb) begin
      predict(s, pend[f].ack_c);
      last = pend[s].ack_c;
      last_a = (s == 0);
    end
    a_req = ra; a_addr = aa;
    b_req = rb; b_addr = ba; b_we = bwe; b_wdata = bwd; b_be = bbe;
    for (int n = 0; n < last - c; n++) begin
      @(negedge clk);
      step_check();
      if (pend[0].v && pend[0].ack_c == cyc) a_req = 1'b0;
      if (pend[1].v && pend[1].ack_c == cyc) b_req = 1'b0;
    end
    a_req = 1'b0;
    b_req = 1'b0;
    pend[0].v = 1'b0;
    pend[1].v = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] r;
    r = '0;
    r[15:14] = 2'($urandom_range(0, 3));
    r[4:0]   = 5'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    logic [31:0] v;
    int sel;
    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      smem[i / 16384][i % 16384] = v;
    end
    for (int k = 0; k < 4; k++) rq[k] = '0;
    model_reset();

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    step_check();
    check("mem_addr_rst", 32'(mem_addr), 32'h0);
    check("mem_wdata_rst", mem_wdata, 32'h0);
    check("mem_mask_rst", 32'(mem_mask_wren), 32'h0);
    check("mem_standby", 32'(mem_standby), 32'h0);
    check("mem_poweroff", 32'(mem_poweroff), 32'hF);
    rst_n = 1'b1;
    idle_gap(2);

    // Directed: wake a sleeping bank, masked write, round-robin ties.
    round(1'b1, 1'b0, 16'h4010, 16'h0, 1'b0, 32'h0, 4'h0);
    idle_gap(1);
    round(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0, 32'h0, 4'h0);
    idle_gap(1);
    round(1'b0, 1'b1, 16'h0, 16'h0005, 1'b1, 32'hDEADBEEF, 4'b0101);
    idle_gap(1);
    round(1'b0, 1'b1, 16'h0, 16'h0005, 1'b0, 32'h0, 4'h0);
    idle_gap(1);
    for (int r = 0; r < 3; r++) begin
      round(1'b1, 1'b1, 16'h0005, 16'h0006, 1'b1, $urandom, 4'hF);
      idle_gap(1);
    end

    // Bank 2 idle boundary: request at count IDLE-1, then at IDLE.
    round(1'b1, 1'b0, 16'h8000, 16'h0, 1'b0, 32'h0, 4'h0);
    idle_gap(int'(IDLE));
    round(1'b1, 1'b0, 16'h8001, 16'h0, 1'b0, 32'h0, 4'h0);
    idle_gap(int'(IDLE) + 1);
    round(1'b0, 1'b1, 16'h0, 16'h8002, 1'b0, 32'h0, 4'h0);
    idle_gap(1);

    // Randomized traffic.
    for (int r = 0; r < 200; r++) begin
      sel = $urandom_range(0, 2);
      round(sel != 1, sel != 0, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
            $urandom, 4'($urandom_range(0, 15)));
      idle_gap($urandom_range(1, 2 * IDLE + 3));
    end

    // Reset in the middle of a transaction.
    idle_gap(int'(IDLE) + 3);
    a_req = 1'b1; a_addr = 16'hC001;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_a_ack", 32'(a_ack), 32'h0);
    check("rst_mem_cs", 32'(mem_cs), 32'h0);
    check("rst_mem_wren", 32'(mem_wren), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_mask", 32'(mem_mask_wren), 32'h0);
    check("rst_a_rdata", a_rdata, 32'h0);
    check("rst_mem_sleep", 32'(mem_sleep), PG ? 32'hF : 32'h0);
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    idle_gap(int'(WAKE) + 4);
    round(1'b1, 1'b0, 16'hC001, 16'h0, 1'b0, 32'h0, 4'h0);
    idle_gap(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
